// File: rtl/max_reduce_pkg.sv
// Shared defaults and state encoding for the max_reduce_stream reduction stage.
package max_reduce_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int CNT_W_DEFAULT  = 16;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} mr_state_t;

endpackage

// File: rtl/max_reduce_stream_umax_pair.sv
// umax_pair: combinational unsigned pairwise max, same compare/select as the
// downstream max datapath. gt flags a strictly greater b.
module umax_pair #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              gt
);

    assign gt = (b > a);
    assign y  = gt ? b : a;

endmodule

// File: rtl/max_reduce_stream.sv
// max_reduce_stream: per-packet unsigned max and saturating beat count with
// valid/ready framing. Optional argmax output enabled by MAX_REDUCE_ARGMAX_EN.
module max_reduce_stream
    import max_reduce_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
`ifdef MAX_REDUCE_ARGMAX_EN
    ,
    output logic [CNT_W-1:0]  out_idx
`endif
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    mr_state_t         state;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              sat;

    logic              accept;
    logic              first;
    logic [DATA_W-1:0] max_y;
    logic              max_gt;
    logic [DATA_W-1:0] nxt_acc;
    logic [CNT_W-1:0]  nxt_cnt;
    logic              nxt_sat;

    umax_pair #(.DATA_W(DATA_W)) u_umax (
        .a  (acc),
        .b  (in_data),
        .y  (max_y),
        .gt (max_gt)
    );

    // in_ready depends only on registered state
    assign in_ready = (state != S_HOLD);
    assign accept   = in_valid & in_ready;
    assign first    = (state == S_IDLE);

    assign nxt_acc  = first ? in_data : max_y;
    assign nxt_cnt  = first ? CNT_W'(1) : sat_inc(cnt);
    assign nxt_sat  = first ? 1'b0 : (sat | (cnt == {CNT_W{1'b1}}));

    // acc is only rewritten when the new beat starts a packet or beats it
    always_ff @(posedge clk) begin
        if (accept && (first || max_gt))
            acc <= nxt_acc;
    end

`ifdef MAX_REDUCE_ARGMAX_EN
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] nxt_idx;

    // beat index equals the pre-increment count, which freezes at saturation
    assign nxt_idx = first ? '0 : (max_gt ? cnt : idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= '0;
            out_idx <= '0;
        end else if (accept) begin
            idx <= nxt_idx;
            if (in_last)
                out_idx <= nxt_idx;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_max   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        cnt <= nxt_cnt;
                        sat <= nxt_sat;
                        if (in_last) begin
                            state     <= S_HOLD;
                            out_valid <= 1'b1;
                            out_max   <= nxt_acc;
                            out_count <= nxt_cnt;
                            out_sat   <= nxt_sat;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        sat       <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
